sync_demux: RTL

//   Registered 1-to-2 demultiplexer. It is the distributing counterpart of SyncMux:
//   one input stream x is steered to output y1 or y2, to both, or to neither, by a
//   per-beat addr. Each output has a one-entry holding register with a valid/ready

---
 rtl/sync_demux.sv | 107 ++++++++++
 1 files changed

// File: rtl/sync_demux.sv
// rtl/sync_demux.sv - registered 1-to-2 demultiplexer with per-output holding slots
// Each output owns one valid/ready slot; addr steers a beat to y1, y2, both, or the drop counter.
module sync_demux #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [W-1:0]     x,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [1:0]       addr,
    output logic [W-1:0]     y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [W-1:0]     y2,
    output logic             y2_valid,
    input  logic             y2_ready,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [1:0] ADDR_Y1    = 2'd0;
    localparam logic [1:0] ADDR_Y2    = 2'd1;
    localparam logic [1:0] ADDR_BCAST = 2'd2;
    localparam logic [1:0] ADDR_DROP  = 2'd3;

    logic [W-1:0]     y1_q, y1_d;
    logic [W-1:0]     y2_q, y2_d;
    logic             y1_valid_q, y1_valid_d;
    logic             y2_valid_q, y2_valid_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic free1, free2;
    logic route1, route2, route_drop;
    logic acc;

    assign free1      = !y1_valid_q || y1_ready;
    assign free2      = !y2_valid_q || y2_ready;
    assign route1     = (addr == ADDR_Y1) || (addr == ADDR_BCAST);
    assign route2     = (addr == ADDR_Y2) || (addr == ADDR_BCAST);
    assign route_drop = (addr == ADDR_DROP);

    // Broadcast demands both slots free so the two loads stay atomic.
    always_comb begin
        x_ready = 1'b0;
        if (!clr) begin
            case (addr)
                ADDR_Y1:    x_ready = free1;
                ADDR_Y2:    x_ready = free2;
                ADDR_BCAST: x_ready = free1 && free2;
                default:    x_ready = 1'b1;
            endcase
        end
    end

    assign acc = x_valid && x_ready;

    always_comb begin
        y1_d       = y1_q;
        y2_d       = y2_q;
        y1_valid_d = y1_valid_q;
        y2_valid_d = y2_valid_q;
        drop_cnt_d = drop_cnt_q;

        // A new load takes priority over a same-cycle drain, giving back-to-back flow.
        if (acc && route1) begin
            y1_d       = x;
            y1_valid_d = 1'b1;
        end else if (y1_valid_q && y1_ready) begin
            y1_valid_d = 1'b0;
        end

        if (acc && route2) begin
            y2_d       = x;
            y2_valid_d = 1'b1;
        end else if (y2_valid_q && y2_ready) begin
            y2_valid_d = 1'b0;
        end

        if (acc && route_drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            y1_q       <= '0;
            y2_q       <= '0;
            y1_valid_q <= 1'b0;
            y2_valid_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            y1_valid_q <= y1_valid_d;
            y2_valid_q <= y2_valid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign y1       = y1_q;
    assign y2       = y2_q;
    assign y1_valid = y1_valid_q;
    assign y2_valid = y2_valid_q;
    assign drop_cnt = drop_cnt_q;

endmodule
